// File: rtl/enet_rgmii_rx_speed_adapter_if.sv
// Bundle of the RGMII receive-side signals around enet_rgmii_rx_speed_adapter.
//
// Signals:
//   ddr_rxd_r / ddr_rxd_f   nibbles captured on the rising / falling edge of the RX clock
//   ddr_ctl_r / ddr_ctl_f   RX_CTL captured on the rising (RX_DV) / falling (DV^ER) edge
//   rx_vld, rx_data, rx_er  framed byte stream towards the MAC
//   rx_sof, rx_eof          frame delimiters, qualified by rx_vld
//   odd_nibble_err          single-cycle pulse: a 10/100 frame ended on a half byte
//   link_up/speed/fdx       decoded link status
//
// Modports:
//   master  the adapter: consumes the DDR samples and drives the byte stream and link status
//   slave   the environment: drives the DDR samples and observes the adapter outputs
interface enet_rgmii_rx_speed_adapter_if;
   logic [3:0] ddr_rxd_r;
   logic [3:0] ddr_rxd_f;
   logic       ddr_ctl_r;
   logic       ddr_ctl_f;
   logic       rx_vld;
   logic [7:0] rx_data;
   logic       rx_er;
   logic       rx_sof;
   logic       rx_eof;
   logic       odd_nibble_err;
   logic       link_up;
   logic [1:0] link_speed;
   logic       link_fdx;

   modport master (
      input  ddr_rxd_r,
      input  ddr_rxd_f,
      input  ddr_ctl_r,
      input  ddr_ctl_f,
      output rx_vld,
      output rx_data,
      output rx_er,
      output rx_sof,
      output rx_eof,
      output odd_nibble_err,
      output link_up,
      output link_speed,
      output link_fdx
   );

   modport slave (
      output ddr_rxd_r,
      output ddr_rxd_f,
      output ddr_ctl_r,
      output ddr_ctl_f,
      input  rx_vld,
      input  rx_data,
      input  rx_er,
      input  rx_sof,
      input  rx_eof,
      input  odd_nibble_err,
      input  link_up,
      input  link_speed,
      input  link_fdx
   );
endinterface

// File: rtl/enet_rgmii_rx_speed_adapter.sv
// Speed-adaptive RGMII receive datapath. Turns per-edge RGMII samples into a framed byte
// stream: DDR bytes at 1000 Mb/s, paired SDR nibbles (low nibble first) at 10/100 Mb/s.
// Link status comes from RGMII in-band status (IBS_EN=1) or from fixed parameters.
//
// Ports:
//   clk    RGMII receive clock (only clock)
//   rst_n  asynchronous active-low reset
//   bus    enet_rgmii_rx_speed_adapter_if.master: DDR samples in; rx_* byte stream,
//          odd_nibble_err and link_* status out. All outputs are registered.
module enet_rgmii_rx_speed_adapter #(
   parameter bit          IBS_EN          = 1'b1,
   parameter logic [1:0]  FIXED_SPEED     = 2'b10,
   parameter int unsigned LINK_STABLE_CYC = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   enet_rgmii_rx_speed_adapter_if.master  bus
);

   localparam logic [1:0] Speed1000 = 2'b10;
   localparam logic [1:0] SpeedRsvd = 2'b11;

   typedef enum logic [1:0] {StIdle, StGig, StNibHi, StNibLo} state_e;

   logic dv;
   logic er;
   assign dv = bus.ddr_ctl_r;
   assign er = bus.ddr_ctl_r ^ bus.ddr_ctl_f;

   // ---------------------------------------------------------------------------------------
   // Link status
   // ---------------------------------------------------------------------------------------
   logic       link_up_q;
   logic [1:0] link_speed_q;
   logic       link_fdx_q;

   if (IBS_EN) begin : g_ibs
      localparam logic [7:0] StableCyc = 8'(LINK_STABLE_CYC);

      logic [3:0] cand_q, cand_d;
      logic [7:0] cnt_q, cnt_d;
      logic       take;

      always_comb begin
         cand_d = cand_q;
         cnt_d  = cnt_q;
         take   = 1'b0;
         // Only samples with both control bits low are status; dv=1 samples leave the
         // debouncer untouched so the link outputs cannot move inside a frame.
         if (!bus.ddr_ctl_r) begin
            if (bus.ddr_ctl_f) begin
               cnt_d = '0;  // carrier extend / false carrier
            end else if (bus.ddr_rxd_r[2:1] == SpeedRsvd) begin
               cnt_d = '0;
            end else begin
               if (cnt_q != '0 && bus.ddr_rxd_r == cand_q) begin
                  if (cnt_q < StableCyc) cnt_d = cnt_q + 8'd1;
               end else begin
                  cand_d = bus.ddr_rxd_r;
                  cnt_d  = 8'd1;
               end
               // Re-taking an already committed candidate rewrites identical values.
               take = (cnt_d == StableCyc);
            end
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cand_q       <= '0;
            cnt_q        <= '0;
            link_up_q    <= 1'b0;
            link_speed_q <= FIXED_SPEED;
            link_fdx_q   <= 1'b0;
         end else begin
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
            if (take) begin
               link_up_q    <= cand_d[0];
               link_speed_q <= cand_d[2:1];
               link_fdx_q   <= cand_d[3];
            end
         end
      end
   end else begin : g_fixed
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            link_up_q    <= 1'b0;
            link_speed_q <= FIXED_SPEED;
            link_fdx_q   <= 1'b0;
         end else begin
            link_up_q    <= 1'b1;
            link_speed_q <= FIXED_SPEED;
            link_fdx_q   <= 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------------------
   // Byte assembly. The active state (StGig vs StNib*) holds the frame speed chosen from
   // link_speed_q on leaving StIdle, so later link changes cannot affect a running frame.
   // ---------------------------------------------------------------------------------------
   state_e     state_q, state_d;
   logic [3:0] lo_nib_q, lo_nib_d;
   logic       lo_er_q, lo_er_d;
   logic       first_q, first_d;

   logic       byte_vld;
   logic [7:0] byte_data;
   logic       byte_er;
   logic       byte_first;
   logic       frame_end;
   logic       odd_err;

   always_comb begin
      state_d    = state_q;
      lo_nib_d   = lo_nib_q;
      lo_er_d    = lo_er_q;
      first_d    = first_q;
      byte_vld   = 1'b0;
      byte_data  = {bus.ddr_rxd_f, bus.ddr_rxd_r};
      byte_er    = er;
      byte_first = first_q;
      frame_end  = 1'b0;
      odd_err    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (dv) begin
               if (link_speed_q == Speed1000) begin
                  byte_vld   = 1'b1;
                  byte_first = 1'b1;
                  first_d    = 1'b0;
                  state_d    = StGig;
               end else begin
                  lo_nib_d = bus.ddr_rxd_r;
                  lo_er_d  = er;
                  first_d  = 1'b1;
                  state_d  = StNibHi;
               end
            end
         end
         StGig: begin
            if (dv) begin
               byte_vld = 1'b1;
            end else begin
               frame_end = 1'b1;
               state_d   = StIdle;
            end
         end
         StNibHi: begin
            if (dv) begin
               byte_vld  = 1'b1;
               byte_data = {bus.ddr_rxd_r, lo_nib_q};
               byte_er   = lo_er_q | er;
               first_d   = 1'b0;
               state_d   = StNibLo;
            end else begin
               odd_err   = 1'b1;  // half byte is dropped
               frame_end = 1'b1;
               state_d   = StIdle;
            end
         end
         StNibLo: begin
            if (dv) begin
               lo_nib_d = bus.ddr_rxd_r;
               lo_er_d  = er;
               state_d  = StNibHi;
            end else begin
               frame_end = 1'b1;
               state_d   = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // ---------------------------------------------------------------------------------------
   // Output staging. One byte is held back so that rx_eof can be attached to it when the
   // frame ends. In 10/100 mode the last byte therefore follows its predecessor by a single
   // cycle: it is released by the dv=0 sample, not by a further byte.
   // ---------------------------------------------------------------------------------------
   logic       hold_vld_q, hold_vld_d;
   logic [7:0] hold_data_q, hold_data_d;
   logic       hold_er_q, hold_er_d;
   logic       hold_first_q, hold_first_d;

   logic       rx_vld_q, rx_vld_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_er_q, rx_er_d;
   logic       rx_sof_q, rx_sof_d;
   logic       rx_eof_q, rx_eof_d;
   logic       odd_q;

   always_comb begin
      hold_vld_d   = hold_vld_q;
      hold_data_d  = hold_data_q;
      hold_er_d    = hold_er_q;
      hold_first_d = hold_first_q;
      rx_vld_d     = 1'b0;
      rx_data_d    = rx_data_q;
      rx_er_d      = 1'b0;
      rx_sof_d     = 1'b0;
      rx_eof_d     = 1'b0;
      if (frame_end) begin
         if (hold_vld_q) begin
            rx_vld_d  = 1'b1;
            rx_data_d = hold_data_q;
            rx_er_d   = hold_er_q;
            rx_sof_d  = hold_first_q;
            rx_eof_d  = 1'b1;
         end
         hold_vld_d = 1'b0;
      end else if (byte_vld) begin
         if (hold_vld_q) begin
            rx_vld_d  = 1'b1;
            rx_data_d = hold_data_q;
            rx_er_d   = hold_er_q;
            rx_sof_d  = hold_first_q;
         end
         hold_vld_d   = 1'b1;
         hold_data_d  = byte_data;
         hold_er_d    = byte_er;
         hold_first_d = byte_first;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         lo_nib_q     <= '0;
         lo_er_q      <= 1'b0;
         first_q      <= 1'b0;
         hold_vld_q   <= 1'b0;
         hold_data_q  <= '0;
         hold_er_q    <= 1'b0;
         hold_first_q <= 1'b0;
         rx_vld_q     <= 1'b0;
         rx_data_q    <= '0;
         rx_er_q      <= 1'b0;
         rx_sof_q     <= 1'b0;
         rx_eof_q     <= 1'b0;
         odd_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         lo_nib_q     <= lo_nib_d;
         lo_er_q      <= lo_er_d;
         first_q      <= first_d;
         hold_vld_q   <= hold_vld_d;
         hold_data_q  <= hold_data_d;
         hold_er_q    <= hold_er_d;
         hold_first_q <= hold_first_d;
         rx_vld_q     <= rx_vld_d;
         rx_data_q    <= rx_data_d;
         rx_er_q      <= rx_er_d;
         rx_sof_q     <= rx_sof_d;
         rx_eof_q     <= rx_eof_d;
         odd_q        <= odd_err;
      end
   end

   assign bus.rx_vld         = rx_vld_q;
   assign bus.rx_data        = rx_data_q;
   assign bus.rx_er          = rx_er_q;
   assign bus.rx_sof         = rx_sof_q;
   assign bus.rx_eof         = rx_eof_q;
   assign bus.odd_nibble_err = odd_q;
   assign bus.link_up        = link_up_q;
   assign bus.link_speed     = link_speed_q;
   assign bus.link_fdx       = link_fdx_q;

endmodule
